// File: rtl/pre_decode_pkg.sv
// Shared frontend types: compacted fetch group bundle and control-flow opcodes.
// Widths track the default pre_decode configuration.
package pre_decode_pkg;

  localparam int PD_FW    = 4;
  localparam int PD_FSQ_W = 5;
  localparam int PD_NUM_W = $clog2(PD_FW) + 1;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [PD_FW-1:0][31:0] inst;
    logic [PD_FW-1:0]       en;
    logic [PD_NUM_W-1:0]    num;
    logic [PD_FSQ_W-1:0]    fsq_idx;
  } pd_group_t;

  function automatic logic is_cfi(input logic [31:0] inst);
    return (inst[6:0] == OPC_BRANCH) ||
           (inst[6:0] == OPC_JAL) ||
           (inst[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/pd_compact.sv
// Combinational compaction of a fetch group: slot start+k lands in entry k,
// enables are contiguous from bit 0.
module pd_compact
  import pre_decode_pkg::*;
#(
  parameter int FETCH_WIDTH = PD_FW,
  parameter int FSQ_W       = PD_FSQ_W,
  localparam int SW         = $clog2(FETCH_WIDTH)
) (
  input  logic [FETCH_WIDTH-1:0][31:0] slots_i,
  input  logic [SW-1:0]                start_i,
  input  logic [SW-1:0]                end_i,
  input  logic [FSQ_W-1:0]             fsq_i,
  output pd_group_t                    grp_o,
  output logic [31:0]                  last_o
);

  logic [SW-1:0] j;

  always_comb begin
    grp_o         = '0;
    j             = '0;
    grp_o.num     = {1'b0, end_i} - {1'b0, start_i} + PD_NUM_W'(1);
    grp_o.fsq_idx = fsq_i;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (PD_NUM_W'(k) < grp_o.num) begin
        j             = start_i + SW'(k);
        grp_o.inst[k] = slots_i[j];
        grp_o.en[k]   = 1'b1;
      end
    end
    last_o = slots_i[end_i];
  end

endmodule

// File: rtl/pre_decode.sv
// Fetch group pre-decoder: compaction, 2-deep group FIFO, all-or-nothing IB write.
// PREDECODE_BR_CHECK_EN adds the taken-slot branch-consistency check (RUN/ERR_WAIT).
module pre_decode
  import pre_decode_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int IBUF_SIZE   = 16,
  parameter int FSQ_W       = 5,
  localparam int SW         = $clog2(FETCH_WIDTH),
  localparam int NW         = $clog2(FETCH_WIDTH) + 1,
  localparam int FREE_W     = $clog2(IBUF_SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [FETCH_WIDTH-1:0][31:0] fetch_inst,
  input  logic [SW-1:0]                fetch_start,
  input  logic [SW-1:0]                fetch_end,
  input  logic [FSQ_W-1:0]             fetch_fsq_idx,
  input  logic                         fetch_taken,
  input  logic [FREE_W-1:0]            ib_free,
  output logic [FETCH_WIDTH-1:0]       ib_en,
  output logic [NW-1:0]                ib_num,
  output logic [FETCH_WIDTH-1:0][31:0] ib_inst,
  output logic [FSQ_W-1:0]             ib_fsq_idx,
  output logic                         pd_err_valid,
  output logic [FSQ_W-1:0]             pd_err_fsq_idx,
  output logic [SW-1:0]                pd_err_offset
);

`ifdef PREDECODE_BR_CHECK_EN
  typedef enum logic {ST_RUN, ST_ERR_WAIT} state_e;
`else
  typedef enum logic {ST_RUN} state_e;
`endif

  pd_group_t   grp;
  pd_group_t   head;
  logic [31:0] last_inst;
  pd_group_t   fifo_q [2];
  pd_group_t   fifo_d [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic        push, pop;

  pd_compact #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .FSQ_W      (FSQ_W)
  ) u_compact (
    .slots_i(fetch_inst),
    .start_i(fetch_start),
    .end_i  (fetch_end),
    .fsq_i  (fetch_fsq_idx),
    .grp_o  (grp),
    .last_o (last_inst)
  );

  assign fetch_ready = (cnt_q < 2'd2) && (state_q == ST_RUN) &&
                       !redirect && !rst;
  assign push = fetch_valid && fetch_ready;
  assign head = fifo_q[head_q];
  // a group is only released when the whole of it fits
  assign pop  = (cnt_q != 2'd0) && (FREE_W'(head.num) <= ib_free) &&
                !redirect && !rst;

  assign ib_en      = pop ? head.en : '0;
  assign ib_num     = pop ? head.num : '0;
  assign ib_inst    = head.inst;
  assign ib_fsq_idx = head.fsq_idx;

`ifdef PREDECODE_BR_CHECK_EN
  logic             br_err;
  logic             err_valid_q, err_valid_d;
  logic [FSQ_W-1:0] err_fsq_q, err_fsq_d;
  logic [SW-1:0]    err_off_q, err_off_d;

  assign br_err = push && fetch_taken && !is_cfi(last_inst);

  assign pd_err_valid   = err_valid_q;
  assign pd_err_fsq_idx = err_fsq_q;
  assign pd_err_offset  = err_off_q;
`else
  logic unused_br;

  assign unused_br      = ^{fetch_taken, last_inst};
  assign pd_err_valid   = 1'b0;
  assign pd_err_fsq_idx = '0;
  assign pd_err_offset  = '0;
`endif

  always_comb begin
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    state_d = state_q;
`ifdef PREDECODE_BR_CHECK_EN
    err_valid_d = 1'b0;
    err_fsq_d   = err_fsq_q;
    err_off_d   = err_off_q;
`endif
    if (redirect) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      cnt_d   = 2'd0;
      state_d = ST_RUN;
    end else begin
      if (push) begin
        fifo_d[tail_q] = grp;
        tail_d         = ~tail_q;
      end
      if (pop) head_d = ~head_q;
      if (push && !pop) cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
`ifdef PREDECODE_BR_CHECK_EN
      if (br_err) begin
        state_d     = ST_ERR_WAIT;
        err_valid_d = 1'b1;
        err_fsq_d   = fetch_fsq_idx;
        err_off_d   = fetch_end;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      cnt_q     <= 2'd0;
      state_q   <= ST_RUN;
`ifdef PREDECODE_BR_CHECK_EN
      err_valid_q <= 1'b0;
      err_fsq_q   <= '0;
      err_off_q   <= '0;
`endif
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
`ifdef PREDECODE_BR_CHECK_EN
      err_valid_q <= err_valid_d;
      err_fsq_q   <= err_fsq_d;
      err_off_q   <= err_off_d;
`endif
    end
  end

endmodule

// File: tb/tb_pre_decode.sv
// Directed + random bench for pre_decode against a queue-of-groups model.
// Honours PREDECODE_BR_CHECK_EN for the branch-consistency expectations.
module tb_pre_decode;

  localparam int FW = 4;
  localparam int FQ = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               redirect;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [FW-1:0][31:0] fetch_inst;
  logic [1:0]         fetch_start;
  logic [1:0]         fetch_end;
  logic [FQ-1:0]      fetch_fsq_idx;
  logic               fetch_taken;
  logic [4:0]         ib_free;
  logic [FW-1:0]      ib_en;
  logic [2:0]         ib_num;
  logic [FW-1:0][31:0] ib_inst;
  logic [FQ-1:0]      ib_fsq_idx;
  logic               pd_err_valid;
  logic [FQ-1:0]      pd_err_fsq_idx;
  logic [1:0]         pd_err_offset;

  always #5 clk = ~clk;

  pre_decode dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_inst    (fetch_inst),
    .fetch_start   (fetch_start),
    .fetch_end     (fetch_end),
    .fetch_fsq_idx (fetch_fsq_idx),
    .fetch_taken   (fetch_taken),
    .ib_free       (ib_free),
    .ib_en         (ib_en),
    .ib_num        (ib_num),
    .ib_inst       (ib_inst),
    .ib_fsq_idx    (ib_fsq_idx),
    .pd_err_valid  (pd_err_valid),
    .pd_err_fsq_idx(pd_err_fsq_idx),
    .pd_err_offset (pd_err_offset)
  );

  typedef struct {
    logic [31:0] w [4];
    int          num;
    int          fsq;
  } grp_t;

  grp_t mq [$];
  int   checks = 0;
  int   errors = 0;
  int   dut_pops = 0;
  bit   err_wait = 0;
  bit   exp_err = 0;
  int   exp_off = 0;
  int   exp_efsq = 0;
  bit   acc = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_cfi(input logic [31:0] i);
    return (i[6:0] == 7'h63) || (i[6:0] == 7'h6f) || (i[6:0] == 7'h67);
  endfunction

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic tick();
    bit          e_rdy;
    bit          e_pop;
    logic [127:0] ei;
    logic [127:0] mask;
    grp_t        g;
    int          s;
    @(negedge clk);
    e_rdy = (mq.size() < 2) && !err_wait && !redirect && !rst;
    e_pop = (mq.size() > 0) && !redirect && !rst &&
            (int'(ib_free) >= mq[0].num);
    chk("fetch_ready", fetch_ready, e_rdy);
    chk("ib_en", ib_en, e_pop ? (1 << mq[0].num) - 1 : 0);
    chk("ib_num", ib_num, e_pop ? mq[0].num : 0);
    chk("pd_err_valid", pd_err_valid, exp_err);
    if (exp_err) begin
      chk("pd_err_offset", pd_err_offset, exp_off);
      chk("pd_err_fsq", pd_err_fsq_idx, exp_efsq);
    end
    if (e_pop) begin
      ei   = '0;
      mask = '0;
      for (int k = 0; k < mq[0].num; k++) begin
        ei[k*32 +: 32]   = mq[0].w[k];
        mask[k*32 +: 32] = '1;
      end
      chk("ib_inst", ib_inst & mask, ei);
      chk("ib_fsq_idx", ib_fsq_idx, mq[0].fsq);
    end
    if (ib_en != '0) dut_pops++;
    acc = fetch_valid && e_rdy;
    @(posedge clk);
    exp_err = 0;
    if (rst || redirect) begin
      mq.delete();
      err_wait = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (acc) begin
        s     = int'(fetch_start);
        g.num = int'(fetch_end) - s + 1;
        for (int k = 0; k < 4; k++) begin
          g.w[k] = 32'h0;
          if (k < g.num) g.w[k] = fetch_inst[s + k];
        end
        g.fsq = int'(fetch_fsq_idx);
        mq.push_back(g);
`ifdef PREDECODE_BR_CHECK_EN
        if (fetch_taken && !is_cfi(fetch_inst[fetch_end])) begin
          err_wait = 1;
          exp_err  = 1;
          exp_off  = int'(fetch_end);
          exp_efsq = int'(fetch_fsq_idx);
        end
`endif
      end
    end
    #1;
  endtask

  task automatic rand_grp();
    int s;
    int e;
    s = $urandom_range(0, 3);
    e = $urandom_range(s, 3);
    fetch_start = 2'(s);
    fetch_end   = 2'(e);
    for (int k = 0; k < FW; k++) fetch_inst[k] = $urandom;
    fetch_fsq_idx = FQ'($urandom);
  endtask

  // Holds the current group on the bus until it is taken or the budget runs out.
  task automatic send(input int max);
    int n;
    n = 0;
    fetch_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc && n < max);
    checks++;
    if (!acc) begin
      errors++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    fetch_valid = 1'b0;
  endtask

  int base;

  initial begin
    rst           = 1'b1;
    redirect      = 1'b0;
    fetch_valid   = 1'b0;
    fetch_inst    = '0;
    fetch_start   = '0;
    fetch_end     = '0;
    fetch_fsq_idx = '0;
    fetch_taken   = 1'b0;
    ib_free       = 5'd16;

    // reset cycle: everything quiet
    tick();
    tick();
    rst = 1'b0;
    tick();

    // compaction: start=1 end=3, slots A..D
    fetch_inst[0] = 32'hAAAA_0001;
    fetch_inst[1] = 32'hBBBB_0002;
    fetch_inst[2] = 32'hCCCC_0003;
    fetch_inst[3] = 32'hDDDD_0004;
    fetch_start   = 2'd1;
    fetch_end     = 2'd3;
    fetch_fsq_idx = 5'd3;
    send(4);
    #1;
    chk("r31_en", ib_en, 4'b0111);
    chk("r31_num", ib_num, 3);
    chk("r31_i0", ib_inst[0], 32'hBBBB_0002);
    chk("r31_i1", ib_inst[1], 32'hCCCC_0003);
    chk("r31_i2", ib_inst[2], 32'hDDDD_0004);
    tick();

    // group of 3 against 2 free, then 3 free
    ib_free     = 5'd2;
    rand_grp();
    fetch_start = 2'd0;
    fetch_end   = 2'd2;
    send(4);
    #1;
    chk("r32_hold0", ib_en, 0);
    tick();
    tick();
    chk("r32_hold1", ib_en, 0);
    ib_free = 5'd3;
    #1;
    chk("r32_write", ib_en, 4'b0111);
    tick();
    chk("r32_empty_en", ib_en, 0);
    chk("r32_ready", fetch_ready, 1);

    // three groups back to back with no room downstream
    ib_free = 5'd0;
    base    = dut_pops;
    for (int i = 0; i < 2; i++) begin
      rand_grp();
      send(3);
    end
    rand_grp();
    fetch_valid = 1'b1;
    #1;
    chk("r33_full", fetch_ready, 0);
    tick();
    tick();
    ib_free = 5'd16;
    send(10);
    repeat (4) tick();
    chk("r33_noloss", dut_pops - base, 3);
    chk("r33_idle", ib_en, 0);

    // redirect with two groups queued
    ib_free = 5'd0;
    for (int i = 0; i < 2; i++) begin
      rand_grp();
      send(3);
    end
    redirect = 1'b1;
    ib_free  = 5'd16;
    #1;
    chk("r34_en", ib_en, 0);
    chk("r34_rdy", fetch_ready, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("r34_ready", fetch_ready, 1);
    chk("r34_cnt0", ib_en, 0);

    // taken end slot holding a non-control-flow instruction
    rand_grp();
    fetch_start   = 2'd0;
    fetch_end     = 2'd2;
    fetch_inst[2] = 32'h0000_0013;
    fetch_fsq_idx = 5'd9;
    fetch_taken   = 1'b1;
    send(3);
    fetch_taken = 1'b0;
    #1;
`ifdef PREDECODE_BR_CHECK_EN
    chk("r35_err", pd_err_valid, 1);
    chk("r35_off", pd_err_offset, 2);
    chk("r35_fsq", pd_err_fsq_idx, 9);
    tick();
    chk("r35_pulse", pd_err_valid, 0);
    chk("r35_stall", fetch_ready, 0);
    repeat (3) tick();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    chk("r35_resume", fetch_ready, 1);
`else
    chk("r35_noerr", pd_err_valid, 0);
    chk("r35_ready", fetch_ready, 1);
    tick();
`endif

    // reset mid-stream with one group queued
    ib_free = 5'd0;
    rand_grp();
    send(3);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    ib_free = 5'd16;
    #1;
    chk("r36_en", ib_en, 0);
    chk("r36_err", pd_err_valid, 0);
    chk("r36_ready", fetch_ready, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      redirect    = ($urandom_range(0, 11) == 0);
      ib_free     = 5'($urandom_range(0, 16));
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_taken = ($urandom_range(0, 5) == 0);
      rand_grp();
      if ($urandom_range(0, 1) == 1)
        fetch_inst[fetch_end][6:0] = 7'h63;
      tick();
    end
    fetch_valid = 1'b0;
    redirect    = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
